c16_mem_arb: RTL and testbench

//   Arbitrates the single-port main RAM between two requesters:
//   - Port A: the c16 CPU (fetch, ld, st).
//   - Port B: a DMA/video reader.

---
 rtl/c16_mem_arb.sv | 157 +++++++++++++++
 tb/tb_c16_mem_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/c16_mem_arb.sv
// Two-port arbiter for the single-port main RAM: CPU (port A) has fixed priority,
// DMA/video (port B) is forced through after MAX_WAIT consecutive A wins.
module c16_mem_arb #(
    parameter int AW       = 15,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [15:0]   a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [15:0]   b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          win_b, win_b_nxt;
    logic          acc_rd, acc_rd_nxt;
    logic          acc_oor, acc_oor_nxt;

    logic          any_req, pick_b, sel_we, sel_oor;
    logic [15:0]   sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          a_gnt_d, b_gnt_d, a_rvalid_d, b_rvalid_d, mem_re_d, mem_we_d;
    logic [DW-1:0] a_rdata_d, b_rdata_d, mem_wdata_d;
    logic [AW-1:0] mem_addr_d;

    // Winner selection; only consulted while IDLE.
    always_comb begin
        any_req   = a_req | b_req;
        pick_b    = b_req & (!a_req | (cnt == 4'(MAX_WAIT)));
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_oor   = (sel_addr >> AW) != 16'd0;
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            win_b     <= 1'b0;
            acc_rd    <= 1'b0;
            acc_oor   <= 1'b0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            win_b     <= win_b_nxt;
            acc_rd    <= acc_rd_nxt;
            acc_oor   <= acc_oor_nxt;
            a_gnt     <= a_gnt_d;
            b_gnt     <= b_gnt_d;
            a_rvalid  <= a_rvalid_d;
            b_rvalid  <= b_rvalid_d;
            a_rdata   <= a_rdata_d;
            b_rdata   <= b_rdata_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
        end
    end

    // Next state, latched access attributes and starvation counter
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        win_b_nxt   = win_b;
        acc_rd_nxt  = acc_rd;
        acc_oor_nxt = acc_oor;
        unique case (state)
            IDLE: begin
                // b_req high with pick_b low means A won over a waiting B.
                if (!b_req || pick_b)
                    cnt_nxt = '0;
                else if (cnt != 4'(MAX_WAIT))
                    cnt_nxt = cnt + 4'd1;
                if (any_req) begin
                    state_nxt   = ACCESS;
                    win_b_nxt   = pick_b;
                    acc_rd_nxt  = !sel_we;
                    acc_oor_nxt = sel_oor;
                end
            end
            ACCESS:  state_nxt = acc_rd ? CAPTURE : IDLE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the next cycle; everything leaves through a register.
    always_comb begin
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        a_rdata_d   = a_rdata;
        b_rdata_d   = b_rdata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    a_gnt_d     = !pick_b;
                    b_gnt_d     = pick_b;
                    mem_addr_d  = sel_addr[AW-1:0];
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we & !sel_oor;
                    mem_re_d    = !sel_we & !sel_oor;
                end
            end
            CAPTURE: begin
                if (win_b) begin
                    b_rvalid_d = 1'b1;
                    b_rdata_d  = acc_oor ? '0 : mem_rdata;
                end else begin
                    a_rvalid_d = 1'b1;
                    a_rdata_d  = acc_oor ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_c16_mem_arb.sv
// Directed bench for c16_mem_arb with a behavioural RAM, a shadow memory and
// per-port read-data scoreboards.
module tb_c16_mem_arb;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk, resetn;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [15:0]   a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [15:0]   b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_re, mem_we;

    c16_mem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro model: registered read, preload port for the bench.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_en)      ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re)      mem_rdata <= ram[mem_addr];
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] shadow [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ctl"}, 32'({a_gnt, a_rvalid, b_gnt, b_rvalid, mem_re, mem_we}), 32'd0);
        check({tag, ".a_rdata"}, 32'(a_rdata), 32'd0);
        check({tag, ".b_rdata"}, 32'(b_rdata), 32'd0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // One access from an IDLE arbiter with the other port quiet. Returns in an IDLE cycle.
    task automatic issue(input bit pb, input bit we, input logic [15:0] addr,
                         input logic [DW-1:0] wd, input string tag);
        int n;
        bit got, oor;
        oor = addr[15];
        if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++;
            got = pb ? b_gnt : a_gnt;
        end
        if (pb) b_req = 1'b0; else a_req = 1'b0;
        check({tag, ".gnt_lat"}, 32'(n), 32'd1);
        check({tag, ".mem_re"}, 32'(mem_re), 32'(!we && !oor));
        check({tag, ".mem_we"}, 32'(mem_we), 32'(we && !oor));
        if (!oor) check({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr[14:0]));
        if (we) begin
            if (!oor) begin
                check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
                shadow[int'(addr[14:0])] = wd;
            end
            @(posedge clk); #1;
            check({tag, ".we_pulse"}, 32'(mem_we), 32'd0);
        end else begin
            if (pb) exp_b.push_back(oor ? '0 : shadow[int'(addr[14:0])]);
            else    exp_a.push_back(oor ? '0 : shadow[int'(addr[14:0])]);
            n = 0; got = 1'b0;
            while (!got && n < 10) begin
                @(posedge clk); #1; n++;
                got = pb ? b_rvalid : a_rvalid;
            end
            check({tag, ".rv_lat"}, 32'(n), 32'd2);
        end
    endtask

    // Scoreboard and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            check("inv.both_gnt", 32'(a_gnt & b_gnt), 32'd0);
            check("inv.re_we", 32'(mem_re & mem_we), 32'd0);
            if (a_rvalid) begin
                check("a_rvalid.expected", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) check("a_rdata", 32'(a_rdata), 32'(exp_a.pop_front()));
            end
            if (b_rvalid) begin
                check("b_rvalid.expected", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) check("b_rdata", 32'(b_rdata), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   n, ng, cnt_b, cnt_s;
    bit   got, rv;
    logic gseq [0:9];

    initial begin
        resetn = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 10; i++) gseq[i] = 1'b0;

        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = 15'h0010; pre_data = 16'hBEEF; shadow[16] = 16'hBEEF;
        @(posedge clk); #1;
        pre_addr = 15'h0003; pre_data = 16'h7777; shadow[3] = 16'h7777;
        @(posedge clk); #1;
        pre_en = 1'b0;
        check_reset("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Plain A read, then A write/read round trip
        issue(1'b0, 1'b0, 16'h0010, '0, "t1.rd");
        issue(1'b0, 1'b1, 16'h0005, 16'h1234, "t2.wr");
        issue(1'b0, 1'b0, 16'h0005, '0, "t2.rd");

        // Port B in-range and out-of-range accesses
        issue(1'b1, 1'b0, 16'h0003, '0, "t4.rd_in");
        issue(1'b1, 1'b0, 16'h8003, '0, "t4.rd_oor");
        issue(1'b1, 1'b1, 16'h8003, 16'h5555, "t4.wr_oor");
        issue(1'b1, 1'b0, 16'h0003, '0, "t4.rd_chk");
        check("t4.a_rdata_hold", 32'(a_rdata), 32'h1234);

        // Both ports requesting continuously
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0100; a_wdata = 16'hAAAA;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0200; b_wdata = 16'hBBBB;
        ng = 0; n = 0;
        while (ng < 10 && n < 60) begin
            @(posedge clk); #1; n++;
            if (a_gnt || b_gnt) begin gseq[ng] = b_gnt; ng++; end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("t3.grants", 32'(ng), 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t3.grant%0d", i), 32'(gseq[i]), 32'(((i + 1) % (MW + 1)) == 0));
        shadow[16'h0100] = 16'hAAAA;
        shadow[16'h0200] = 16'hBBBB;
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 16'h0200, '0, "t3.rd_b_data");
        issue(1'b1, 1'b0, 16'h0100, '0, "t3.rd_a_data");

        // A pulses its request in the same IDLE cycle B requests
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0003;
        @(posedge clk); #1;
        a_req = 1'b0;
        check("t5.a_gnt", 32'(a_gnt), 32'd1);
        check("t5.b_gnt_first", 32'(b_gnt), 32'd0);
        if (a_gnt) exp_a.push_back(shadow[16]);
        n = 1; got = 1'b0;
        while (!got && n < 12) begin
            @(posedge clk); #1; n++;
            got = b_gnt;
        end
        b_req = 1'b0;
        check("t5.b_gnt_lat", 32'(n), 32'd4);
        if (got) exp_b.push_back(shadow[3]);
        repeat (3) @(posedge clk); #1;

        // B withdraws while A is being granted
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0020; a_wdata = 16'h4242;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0021; b_wdata = 16'h9999;
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        check("t5.a_win", 32'(a_gnt), 32'd1);
        check("t5.a_win_addr", 32'(mem_addr), 32'h0020);
        check("t5.no_b_gnt_now", 32'(b_gnt), 32'd0);
        cnt_b = 0; cnt_s = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cnt_b += int'(b_gnt);
            cnt_s += int'(mem_re | mem_we);
        end
        check("t5.no_b_gnt_later", 32'(cnt_b), 32'd0);
        check("t5.no_b_access", 32'(cnt_s), 32'd0);

        // Reset during the CAPTURE cycle of an A read
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        @(posedge clk); #1;
        a_req = 1'b0;
        check("t6.gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check_reset("t6.rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rv |= a_rvalid;
        end
        check("t6.no_rvalid", 32'(rv), 32'd0);
        issue(1'b0, 1'b0, 16'h0005, '0, "t6.after");
        @(posedge clk); #1;

        check("end.a_queue", 32'(exp_a.size()), 32'd0);
        check("end.b_queue", 32'(exp_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
